lsu: RTL and testbench
======================

# lsu

Load/store unit directly downstream of the ALU in the execute path. It takes `alu_result` as the effective address and runs one data-memory transaction per load or store over a req/gnt/rvalid bus. It produces byte enables and lane-replicated write data, and aligns and sign- or zero-extends load data. It holds the core with `stall` until the access completes, and flags misaligned or illegal accesses without touching the bus.

## Interface
Parameters:
- `ADDR_W`, default 32: address width; only 32 is supported.
- `DATA_W`, default 32: data width; only 32 is supported.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  system clock; all state updates on the rising edge.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Core side:
  - `mem_en`  in  1  the current instruction is a load or store; held by the core until `done`.
  - `mem_we`  in  1  1 = store, 0 = load.
  - `funct3`  in  3  access size and signedness (RV32I encoding).
  - `alu_result`  in  32  effective address from the ALU.
  - `store_data`  in  32  rs2 value.
  - `stall`  out  1  core must hold PC and inputs.
  - `done`  out  1  one-cycle completion pulse.
  - `fault`  out  1  one-cycle pulse together with `done` on a misaligned or illegal access.
  - `load_data`  out  32  extended load result, valid while `done`=1 and `mem_we`=0.
- Bus side:
  - `bus_req`  out  1  transaction request.
  - `bus_addr`  out  32  word-aligned address (`{addr[31:2],2'b00}`).
  - `bus_we`  out  1  write strobe.
  - `bus_be`  out  4  byte enables.
  - `bus_wdata`  out  32  lane-replicated store data.
  - `bus_gnt`  in  1  request accepted.
  - `bus_rvalid`  in  1  read data valid.
  - `bus_rdata`  in  32  read data.

## Operation
- **Sizes by `funct3`:** 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores: only 000, 001 and 010 are legal.
  - Any other code is illegal and raises `fault`.
- **Misaligned:**
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
- **State machine:** IDLE, REQ, WAIT, DONE.
  - IDLE: when `mem_en`=1, register the address, `be`, `wdata`, `we` and `funct3`.
    - Legal access → REQ.
    - Misaligned or illegal → DONE with the fault flag set; no bus activity.
  - REQ: `bus_req`=1 with the registered fields until `bus_gnt`=1.
    - On a store → DONE.
    - On a load → WAIT.
  - WAIT: on `bus_rvalid`=1, register the extended `bus_rdata` → DONE.
  - DONE: `done`=1 and `fault` = registered flag → IDLE.
- **`stall`:** `stall = mem_en & ~done`, so it is low in the DONE cycle, when the core advances.
- **Byte enables:**
  - SB: `be = 4'b0001<<addr[1:0]`, `wdata = {4{sd[7:0]}}`.
  - SH: `be = 4'b0011<<{addr[1],1'b0}`, `wdata = {2{sd[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = sd`.
- **Load extraction:**
  - B/BU: byte lane `addr[1:0]`.
  - H/HU: halfword lane `addr[1]`.
  - B and H are sign-extended from bit 7 or bit 15; BU and HU are zero-extended.
- **Load with `be`:** loads drive `be` = the access lanes; the bus may ignore it.
- **Fault data:** a fault returns `load_data` = 0.

## Timing
- **Reset values:** state IDLE; `stall`=0 unless `mem_en`=1.
  - All other outputs reset to 0: `done`, `fault`, `load_data`, `bus_req`, `bus_addr`, `bus_we`, `bus_be`, `bus_wdata`.
- **Bus outputs are registered:** every bus output comes from a flop.
- **Minimum latency,** with `bus_gnt` in the first REQ cycle and `bus_rvalid` one cycle later:
  - Load: `done` in cycle 3 after `mem_en` rises; `stall` high in cycles 0–2.
  - Store: `done` in cycle 2.
  - Fault: `done` in cycle 1.
- **`bus_req` hold:** `bus_req` stays high with stable fields until `bus_gnt`. It drops in the cycle after gnt is sampled.
- **`bus_rvalid` timing:** only sampled in WAIT.
  - `bus_rvalid` coincident with gnt is a protocol violation and is ignored.
  - Unbounded wait in WAIT is allowed.
- **Back-to-back:** after DONE, IDLE samples the next instruction's `mem_en` in the following cycle, so there is one bubble cycle between transactions.
- **Reset mid-transaction:** asynchronous. State goes to IDLE and `bus_req` drops immediately; any outstanding read response is discarded.

## Structure
- Shared package/header:
  - `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - LSU state encoding.
  - Both are shared with the decoder and tb.
- Sub-module `lsu_align`: combinational.
  - Store lane steering: `be` and `wdata` from `addr`, `funct3`, `store_data`.
  - Load extraction and extension from `rdata`, `addr[1:0]`, `funct3`.
  - Fault detection.
  - The `lsu` top holds the FSM and registers.

## Test plan
- **LW, immediate gnt:** addr 0x100, `bus_rdata` 0xDEADBEEF, gnt in REQ, rvalid next cycle → `bus_addr` 0x100, `be` 1111, `done` in cycle 3, `load_data` 0xDEADBEEF, `stall` high for exactly 3 cycles.
- **LB / LBU, byte lane 3:** addr 0x103, rdata 0x80123456.
  - LB → `load_data` 0xFFFFFF80.
  - LBU → 0x00000080.
  - Both with `be` 1000.
- **SH, upper half:** addr 0x202, `store_data` 0x0000ABCD → `be` 1100, `wdata` 0xABCDABCD, `bus_we`=1, `done` in cycle 2, gnt delayed 4 cycles holds `bus_req` and fields stable.
- **Faults:**
  - LW at 0x102 → `fault`=1 and `done` in cycle 1, `bus_req` never asserted.
  - Store with `funct3`=100 → same response.
- **Back-to-back:** SB 0x55 at 0x001 (`be` 0010, `wdata` 0x55555555), then LHU at 0x002 with rdata 0xFFEE0000 → `load_data` 0x0000FFEE, one idle cycle between the two requests.
- **Reset in WAIT:** `rst_n` pulsed low in WAIT → `bus_req`/`stall` drop immediately; a later rvalid is ignored, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes and
// the LSU state encoding, used by the decoder, the LSU and its bench.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replication, access
// fault detection, and load byte/halfword extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        fault,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic        illegal;
    logic        misaligned;
    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        be         = 4'b0000;
        wdata      = '0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << addr;
                wdata = {4{store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << {addr[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                misaligned = addr[0];
            end
            F3_W: begin
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = |addr;
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants have no meaning for stores
        if (we && (funct3 == F3_BU || funct3 == F3_HU))
            illegal = 1'b1;
        fault = illegal | misaligned;
    end

    always_comb begin
        lb = rdata[7:0];
        case (ld_addr)
            2'd0: lb = rdata[7:0];
            2'd1: lb = rdata[15:8];
            2'd2: lb = rdata[23:16];
            2'd3: lb = rdata[31:24];
            default: lb = rdata[7:0];
        endcase
        lh = ld_addr[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{lb[7]}}, lb};
            F3_BU:   ld_data = {24'b0, lb};
            F3_H:    ld_data = {{16{lh[15]}}, lh};
            F3_HU:   ld_data = {16'b0, lh};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus transaction per load/store, registered bus
// outputs, core stall until completion, faults reported without bus use.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] load_data,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              flt_q, flt_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] ld_q, ld_d;

    logic [3:0]        a_be;
    logic [DATA_W-1:0] a_wdata;
    logic              a_fault;
    logic [DATA_W-1:0] a_ld;

    lsu_align u_align (
        .we         (mem_we),
        .funct3     (funct3),
        .addr       (alu_result[1:0]),
        .store_data (store_data),
        .be         (a_be),
        .wdata      (a_wdata),
        .fault      (a_fault),
        .ld_funct3  (f3_q),
        .ld_addr    (addr_q[1:0]),
        .rdata      (bus_rdata),
        .ld_data    (a_ld)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        flt_d   = flt_q;
        req_d   = req_q;
        ld_d    = ld_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_en) begin
                    addr_d  = alu_result;
                    f3_d    = funct3;
                    we_d    = mem_we;
                    be_d    = a_be;
                    wdata_d = a_wdata;
                    flt_d   = a_fault;
                    if (a_fault) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        ld_d    = '0;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    ld_d    = a_ld;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            flt_q   <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            flt_q   <= flt_d;
            done_q  <= done_d;
            req_q   <= req_d;
            ld_q    <= ld_d;
        end
    end

    assign stall     = mem_en & ~done_q;
    assign done      = done_q;
    assign fault     = done_q & flt_q;
    assign load_data = ld_q;
    assign bus_req   = req_q;
    assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of single accesses plus
// delayed-grant, back-to-back and reset-in-WAIT sequences.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        flt;
        logic [31:0] ld;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en, mem_we;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic        stall, done, fault;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .alu_result (alu_result),
        .store_data (store_data),
        .stall      (stall),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        mem_en     = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    task automatic run(input string nm, input vec_t t, input int gd,
                       output int done_abs, output int req_abs);
        int k, nreq, stalls;
        logic saw, bad, got, pend, flt_seen;
        logic [31:0] a0, w0;
        logic [3:0] b0;
        logic we0;
        @(posedge clk);
        #1;
        mem_en = 1'b1; mem_we = t.we; funct3 = t.f3;
        alu_result = t.addr; store_data = t.sd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        k = 0; nreq = 0; stalls = 0;
        saw = 0; bad = 0; got = 0; pend = 0; flt_seen = 0;
        a0 = '0; w0 = '0; b0 = '0; we0 = 0;
        done_abs = -1; req_abs = -1;
        while (k < 60 && !got) begin
            @(negedge clk);
            if (stall) stalls++;
            bus_rvalid = pend;
            bus_rdata  = pend ? t.rdata : 32'h0;
            pend = 0;
            if (done) begin
                got = 1; done_abs = cyc; flt_seen = fault;
                bus_gnt = 1'b0;
            end else begin
                if (bus_req) begin
                    if (!saw) begin
                        saw = 1; req_abs = cyc;
                        a0 = bus_addr; w0 = bus_wdata;
                        b0 = bus_be; we0 = bus_we;
                    end else if (bus_addr !== a0 || bus_wdata !== w0 ||
                                 bus_be !== b0 || bus_we !== we0) begin
                        bad = 1;
                    end
                    nreq++;
                    bus_gnt = (nreq > gd);
                    if (bus_gnt && !t.we) pend = 1;
                end else begin
                    bus_gnt = 1'b0;
                end
                k++;
            end
        end
        chk({nm, " done_seen"}, {31'b0, got}, 32'd1);
        if (got) begin
            chk({nm, " latency"}, k, t.flt ? 1 : t.lat + gd);
            chk({nm, " stall_cycles"}, stalls, k);
            chk({nm, " fault"}, {31'b0, flt_seen}, {31'b0, t.flt});
            if (t.flt) begin
                chk({nm, " no_req"}, {31'b0, saw}, 32'd0);
                chk({nm, " fault_data"}, load_data, 32'd0);
            end else begin
                chk({nm, " addr"}, a0, t.addr & 32'hFFFF_FFFC);
                chk({nm, " be"}, {28'b0, b0}, {28'b0, t.be});
                chk({nm, " we"}, {31'b0, we0}, {31'b0, t.we});
                chk({nm, " stable"}, {31'b0, bad}, 32'd0);
                if (t.we) chk({nm, " wdata"}, w0, t.wdata);
                else      chk({nm, " load"}, load_data, t.ld);
            end
        end
    endtask

    vec_t v[12];
    vec_t tsh, tsb, tlhu;
    int d1, r1, d2, r2;

    initial begin
        v[0]  = '{0, F3_W,  32'h100, 0, 32'hDEADBEEF, 4'b1111, 0, 0, 32'hDEADBEEF, 3};
        v[1]  = '{0, F3_B,  32'h103, 0, 32'h80123456, 4'b1000, 0, 0, 32'hFFFFFF80, 3};
        v[2]  = '{0, F3_BU, 32'h103, 0, 32'h80123456, 4'b1000, 0, 0, 32'h00000080, 3};
        v[3]  = '{0, F3_H,  32'h102, 0, 32'h80123456, 4'b1100, 0, 0, 32'hFFFF8012, 3};
        v[4]  = '{0, F3_HU, 32'h100, 0, 32'h80123456, 4'b0011, 0, 0, 32'h00003456, 3};
        v[5]  = '{0, F3_B,  32'h101, 0, 32'h00007F00, 4'b0010, 0, 0, 32'h0000007F, 3};
        v[6]  = '{1, F3_W,  32'h204, 32'h12345678, 0, 4'b1111, 32'h12345678, 0, 0, 2};
        v[7]  = '{1, F3_B,  32'h001, 32'h00000055, 0, 4'b0010, 32'h55555555, 0, 0, 2};
        v[8]  = '{0, F3_W,  32'h102, 0, 0, 0, 0, 1, 0, 1};
        v[9]  = '{1, 3'b100, 32'h100, 32'h1, 0, 0, 0, 1, 0, 1};
        v[10] = '{0, F3_H,  32'h101, 0, 0, 0, 0, 1, 0, 1};
        v[11] = '{0, 3'b011, 32'h100, 0, 0, 0, 0, 1, 0, 1};
        tsh  = '{1, F3_H,  32'h202, 32'h0000ABCD, 0, 4'b1100, 32'hABCDABCD, 0, 0, 2};
        tsb  = '{1, F3_B,  32'h001, 32'h00000055, 0, 4'b0010, 32'h55555555, 0, 0, 2};
        tlhu = '{0, F3_HU, 32'h002, 0, 32'hFFEE0000, 4'b1100, 0, 0, 32'h0000FFEE, 3};

        rst_n = 1'b0; mem_en = 1'b0; mem_we = 1'b0; funct3 = '0;
        alu_result = '0; store_data = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst done_fault", {30'b0, done, fault}, 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst bus_ctl", {26'b0, bus_req, bus_we, bus_be}, 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run($sformatf("vec%0d", i), v[i], 0, d1, r1);
            idle();
        end

        run("sh_gnt4", tsh, 4, d1, r1);
        idle();

        run("b2b_sb", tsb, 0, d1, r1);
        run("b2b_lhu", tlhu, 0, d2, r2);
        chk("b2b gap", r2 - d1, 32'd2);
        idle();

        @(posedge clk);
        #1;
        mem_en = 1'b1; mem_we = 1'b0; funct3 = F3_W; alu_result = 32'h100;
        @(negedge clk);
        @(negedge clk);
        chk("rw req", {31'b0, bus_req}, 32'd1);
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; mem_en = 1'b0;
        #1;
        chk("rw req_drop", {31'b0, bus_req}, 32'd0);
        chk("rw stall_drop", {31'b0, stall}, 32'd0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("rw no_done", {31'b0, done}, 32'd0);
        chk("rw no_data", load_data, 32'd0);
        @(negedge clk);
        chk("rw no_done2", {31'b0, done}, 32'd0);
        run("rw_next_lw", v[0], 0, d1, r1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
